// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity and stop-bit
// mode constants, and a parity helper usable by both TX and a future RX.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

    // Widest frame payload any UART block in this slice supports
    localparam int MAX_DATA_BITS = 9;

    // Parity over a zero-extended payload; unused upper bits are zero so
    // they do not disturb the XOR reduction.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic                     mode);
        return (mode == PARITY_EVEN) ? (^data) : ~(^data);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: synchronous, show-ahead read data, registered occupancy.
// Writes while full and reads while empty are ignored.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written so it has no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: FIFO-buffered words are framed as
// start, LSB-first data, optional parity and one or two stop bits, with
// every bit lasting OS_RATE oversample strobes.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OS_RATE    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick_os,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop2,
    output logic                          tx_serial,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // The tick counter must reach 2*OS_RATE-1 for a double stop bit
    localparam int TICK_W = $clog2(2 * OS_RATE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] BIT_END   = TICK_W'(OS_RATE - 1);
    localparam logic [TICK_W-1:0] STOP2_END = TICK_W'(2 * OS_RATE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    uart_state_t          state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 stop_mode_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 pop;
    logic                 bit_end;
    logic                 stop_end;
    logic [TICK_W-1:0]    stop_last;

    // Readiness depends only on occupancy, never on a same-cycle pop
    assign tx_ready = !fifo_full;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Bit-period end detection and the FIFO pop request, which happens when
    // idle with data waiting or at the last stop tick for back-to-back frames
    always_comb begin
        stop_last = (stop_mode_q == STOP_TWO) ? STOP2_END : BIT_END;
        bit_end   = tick_os && (tick_cnt == BIT_END);
        stop_end  = tick_os && (tick_cnt == stop_last);
        pop       = 1'b0;
        if (!fifo_empty) begin
            if (state == ST_IDLE) begin
                pop = 1'b1;
            end else if ((state == ST_STOP) && stop_end) begin
                pop = 1'b1;
            end
        end
    end

    // Frame sequencer: state, counters, shift register, latched frame config
    // and the registered line, busy and done outputs all move together
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop_mode_q <= STOP_ONE;
            tx_serial   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tick_cnt <= '0;
                    if (pop) begin
                        shift       <= fifo_rd_data;
                        par_en_q    <= parity_en;
                        par_bit_q   <= parity_bit(MAX_DATA_BITS'(fifo_rd_data), parity_odd);
                        stop_mode_q <= stop2;
                        state       <= ST_START;
                        tx_serial   <= 1'b0;
                        busy        <= 1'b1;
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        state     <= ST_DATA;
                        tick_cnt  <= '0;
                        bit_cnt   <= '0;
                        tx_serial <= shift[0];
                    end else if (tick_os) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            if (par_en_q) begin
                                state     <= ST_PARITY;
                                tx_serial <= par_bit_q;
                            end else begin
                                state     <= ST_STOP;
                                tx_serial <= 1'b1;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            shift     <= shift >> 1;
                            tx_serial <= shift[1];
                        end
                    end else if (tick_os) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end

                ST_PARITY: begin
                    if (bit_end) begin
                        state     <= ST_STOP;
                        tick_cnt  <= '0;
                        tx_serial <= 1'b1;
                    end else if (tick_os) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end

                ST_STOP: begin
                    if (stop_end) begin
                        done     <= 1'b1;
                        tick_cnt <= '0;
                        if (pop) begin
                            shift       <= fifo_rd_data;
                            par_en_q    <= parity_en;
                            par_bit_q   <= parity_bit(MAX_DATA_BITS'(fifo_rd_data), parity_odd);
                            stop_mode_q <= stop2;
                            state       <= ST_START;
                            tx_serial   <= 1'b0;
                            busy        <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            tx_serial <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end else if (tick_os) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    tick_cnt  <= '0;
                    tx_serial <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: a default-parameter instance and a
// 5-bit / 16x-oversample instance share clock, reset, tick and config.
module tb_uart_tx_param;

    logic       clk;
    logic       rst;
    logic       tick_os;
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;

    logic       tx_valid_a;
    logic [7:0] tx_data_a;
    logic       tx_ready_a;
    logic       tx_serial_a;
    logic       busy_a;
    logic       done_a;
    logic [2:0] fifo_count_a;

    logic       tx_valid_b;
    logic [4:0] tx_data_b;
    logic       tx_ready_b;
    logic       tx_serial_b;
    logic       busy_b;
    logic       done_b;
    logic [2:0] fifo_count_b;

    int checks = 0;
    int errors = 0;
    int tick_phase = 0;

    uart_tx_param u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .tick_os    (tick_os),
        .tx_valid   (tx_valid_a),
        .tx_data    (tx_data_a),
        .tx_ready   (tx_ready_a),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .tx_serial  (tx_serial_a),
        .busy       (busy_a),
        .done       (done_a),
        .fifo_count (fifo_count_a)
    );

    uart_tx_param #(
        .DATA_BITS (5),
        .OS_RATE   (16)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .tick_os    (tick_os),
        .tx_valid   (tx_valid_b),
        .tx_data    (tx_data_b),
        .tx_ready   (tx_ready_b),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .tx_serial  (tx_serial_b),
        .busy       (busy_b),
        .done       (done_b),
        .fifo_count (fifo_count_b)
    );

    // 10 ns system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample strobe: one cycle high out of every three
    initial begin
        tick_os = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_phase = (tick_phase == 2) ? 0 : tick_phase + 1;
            tick_os = (tick_phase == 0);
        end
    end

    // Hard stop in case a wait inside the sequence never resolves
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic line_of(input bit sel);
        return sel ? tx_serial_b : tx_serial_a;
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    function automatic logic done_of(input bit sel);
        return sel ? done_b : done_a;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One-cycle write pulse; must be called away from a rising edge
    task automatic applyStimulus(input bit sel, input logic [7:0] data);
        if (sel) begin
            tx_valid_b = 1'b1;
            tx_data_b  = data[4:0];
        end else begin
            tx_valid_a = 1'b1;
            tx_data_a  = data;
        end
        @(posedge clk);
        #1;
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
    endtask

    task automatic waitTicks(input int n);
        int seen;
        seen = 0;
        while (seen < n) begin
            @(negedge clk);
            if (tick_os === 1'b1) seen++;
        end
    endtask

    // Called on a falling edge. Waits for the start bit, then checks every
    // tick of every bit against the expected serial level (bit 0 first),
    // then the done pulse and what follows the frame.
    task automatic captureFrame(input string tag, input bit sel,
                                input logic [15:0] exp_bits, input int nbits,
                                input int os, input bit expect_idle);
        int   waited;
        logic bad_lvl;
        waited = 0;
        while (line_of(sel) !== 1'b0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_start_seen"}, {31'b0, line_of(sel)}, 32'd0);
        if (line_of(sel) !== 1'b0) return;
        for (int b = 0; b < nbits; b++) begin
            bad_lvl = exp_bits[b];
            for (int t = 0; t < os; t++) begin
                while (tick_os !== 1'b1) @(negedge clk);
                if (line_of(sel) !== exp_bits[b]) bad_lvl = line_of(sel);
                @(negedge clk);
            end
            checkOutput($sformatf("%s_bit%0d", tag, b), {31'b0, bad_lvl},
                        {31'b0, exp_bits[b]});
        end
        checkOutput({tag, "_done"}, {31'b0, done_of(sel)}, 32'd1);
        if (expect_idle) begin
            checkOutput({tag, "_idle_busy"}, {31'b0, busy_of(sel)}, 32'd0);
            checkOutput({tag, "_idle_line"}, {31'b0, line_of(sel)}, 32'd1);
            @(negedge clk);
            checkOutput({tag, "_done_drop"}, {31'b0, done_of(sel)}, 32'd0);
        end else begin
            checkOutput({tag, "_next_start"}, {31'b0, line_of(sel)}, 32'd0);
            checkOutput({tag, "_next_busy"}, {31'b0, busy_of(sel)}, 32'd1);
        end
    endtask

    // Directed sequence
    initial begin
        int low_seen;
        int done_seen;

        rst        = 1'b1;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        tx_valid_a = 1'b0;
        tx_data_a  = '0;
        tx_valid_b = 1'b0;
        tx_data_b  = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_line_a", {31'b0, tx_serial_a}, 32'd1);
        checkOutput("rst_busy_a", {31'b0, busy_a}, 32'd0);
        checkOutput("rst_done_a", {31'b0, done_a}, 32'd0);
        checkOutput("rst_ready_a", {31'b0, tx_ready_a}, 32'd1);
        checkOutput("rst_count_a", {29'b0, fifo_count_a}, 32'd0);
        checkOutput("rst_line_b", {31'b0, tx_serial_b}, 32'd1);
        checkOutput("rst_count_b", {29'b0, fifo_count_b}, 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] frame 0xA5, no parity, one stop");
        fork
            begin
                @(negedge clk);
                captureFrame("a5", 1'b0, 16'h034A, 10, 8, 1'b1);
            end
            begin
                applyStimulus(1'b0, 8'hA5);
                checkOutput("a5_line_after_write", {31'b0, tx_serial_a}, 32'd1);
                checkOutput("a5_count_after_write", {29'b0, fifo_count_a}, 32'd1);
                @(posedge clk);
                #1;
                checkOutput("a5_line_after_pop", {31'b0, tx_serial_a}, 32'd0);
                checkOutput("a5_busy_after_pop", {31'b0, busy_a}, 32'd1);
                checkOutput("a5_count_after_pop", {29'b0, fifo_count_a}, 32'd0);
            end
        join

        $display("[TB] frame 0x07, even parity, config changed mid-frame");
        fork
            begin
                @(negedge clk);
                captureFrame("par_even", 1'b0, 16'h060E, 11, 8, 1'b1);
            end
            begin
                parity_en  = 1'b1;
                parity_odd = 1'b0;
                stop2      = 1'b0;
                applyStimulus(1'b0, 8'h07);
                repeat (30) @(posedge clk);
                #1;
                parity_odd = 1'b1;
                stop2      = 1'b1;
                parity_en  = 1'b0;
            end
        join

        $display("[TB] frame 0x07, odd parity");
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        stop2      = 1'b0;
        fork
            begin
                @(negedge clk);
                captureFrame("par_odd", 1'b0, 16'h040E, 11, 8, 1'b1);
            end
            applyStimulus(1'b0, 8'h07);
        join

        $display("[TB] frame 0x00, two stop bits");
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b1;
        fork
            begin
                @(negedge clk);
                captureFrame("stop2", 1'b0, 16'h0600, 11, 8, 1'b1);
            end
            applyStimulus(1'b0, 8'h00);
        join
        stop2 = 1'b0;

        $display("[TB] six back-to-back writes");
        fork
            begin
                @(negedge clk);
                captureFrame("b2b_0", 1'b0, 16'h0222, 10, 8, 1'b0);
                captureFrame("b2b_1", 1'b0, 16'h0244, 10, 8, 1'b0);
                captureFrame("b2b_2", 1'b0, 16'h0266, 10, 8, 1'b0);
                captureFrame("b2b_3", 1'b0, 16'h0288, 10, 8, 1'b0);
                captureFrame("b2b_4", 1'b0, 16'h02AA, 10, 8, 1'b1);
            end
            begin
                applyStimulus(1'b0, 8'h11);
                applyStimulus(1'b0, 8'h22);
                applyStimulus(1'b0, 8'h33);
                applyStimulus(1'b0, 8'h44);
                checkOutput("b2b_ready_three", {31'b0, tx_ready_a}, 32'd1);
                checkOutput("b2b_count_three", {29'b0, fifo_count_a}, 32'd3);
                applyStimulus(1'b0, 8'h55);
                checkOutput("b2b_ready_full", {31'b0, tx_ready_a}, 32'd0);
                checkOutput("b2b_count_full", {29'b0, fifo_count_a}, 32'd4);
                applyStimulus(1'b0, 8'h66);
                checkOutput("b2b_count_drop", {29'b0, fifo_count_a}, 32'd4);
                checkOutput("b2b_ready_drop", {31'b0, tx_ready_a}, 32'd0);
            end
        join

        $display("[TB] 5-bit, 16x instance, frame 0x1F");
        fork
            begin
                @(negedge clk);
                captureFrame("b_1f", 1'b1, 16'h007E, 7, 16, 1'b1);
            end
            applyStimulus(1'b1, 8'h1F);
        join

        $display("[TB] reset during data bit 3");
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        waitTicks(36);
        checkOutput("rst_mid_line", {31'b0, tx_serial_a}, 32'd0);
        checkOutput("rst_mid_busy", {31'b0, busy_a}, 32'd1);
        checkOutput("rst_mid_count", {29'b0, fifo_count_a}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_abort_line", {31'b0, tx_serial_a}, 32'd1);
        checkOutput("rst_abort_busy", {31'b0, busy_a}, 32'd0);
        checkOutput("rst_abort_count", {29'b0, fifo_count_a}, 32'd0);
        checkOutput("rst_abort_ready", {31'b0, tx_ready_a}, 32'd1);
        checkOutput("rst_abort_done", {31'b0, done_a}, 32'd0);
        rst = 1'b0;
        low_seen  = 0;
        done_seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx_serial_a !== 1'b1) low_seen++;
            if (done_a !== 1'b0) done_seen++;
        end
        checkOutput("rst_after_no_frame", low_seen, 32'd0);
        checkOutput("rst_after_no_done", done_seen, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-002 Parameter DATA_BITS, default 8, SHALL set data bits per frame; legal range 5..9.
REQ-003 Parameter OS_RATE, default 8, SHALL set oversample ticks per bit period; legal range 2..16.
REQ-004 Parameter FIFO_DEPTH, default 4, SHALL set transmit FIFO entries; power of 2, minimum 2.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 tick_os  in  1  single-cycle oversample strobe, OS_RATE strobes per bit.
REQ-008 tx_valid  in  1  write request for tx_data.
REQ-009 tx_data  in  DATA_BITS  frame payload.
REQ-010 tx_ready  out  1  FIFO can accept a word.
REQ-011 parity_en  in  1  1 = parity bit inserted after the data bits.
REQ-012 parity_odd  in  1  1 = odd parity, 0 = even parity.
REQ-013 stop2  in  1  1 = two stop bits, 0 = one stop bit.
REQ-014 tx_serial  out  1  serial line, registered, idle high.
REQ-015 busy  out  1  high whenever the FSM is not IDLE.
REQ-016 done  out  1  one-cycle pulse at end of each frame.
REQ-017 fifo_count  out  clog2(FIFO_DEPTH)+1  words waiting in the FIFO.

Function
REQ-018 A word SHALL be written on each rising edge where tx_valid and tx_ready are both high; tx_ready SHALL equal not-full, independent of a same-cycle pop.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
- IDLE with FIFO non-empty: pop, load shift register, latch parity_en/parity_odd/stop2, go to START.
- START: tx_serial 0 for OS_RATE ticks, then DATA.
- DATA: LSB first, DATA_BITS bits of OS_RATE ticks each, then PARITY if latched parity_en, else STOP.
- PARITY: one bit period; value is XOR of data bits, inverted when parity_odd.
- STOP: tx_serial 1 for OS_RATE ticks, or 2*OS_RATE ticks when stop2 is latched.
REQ-020 A bit period SHALL end on its OS_RATE-th tick_os; the tick counter SHALL clear on every state entry; tick_os SHALL be ignored in IDLE.
REQ-021 tx_serial SHALL be registered and change on the same edge as the state change; a word accepted on edge k SHALL drive tx_serial low after edge k+1 if the FSM was IDLE with an empty FIFO.
REQ-022 At the final STOP tick: if the FIFO is non-empty, the FSM SHALL pop and enter START directly with no idle cycle; otherwise it SHALL enter IDLE.
REQ-023 done SHALL be registered and high for exactly one cycle, coincident with the edge that leaves STOP.
REQ-024 Changes to config inputs mid-frame SHALL NOT affect the frame in progress.
REQ-025 A write attempted while full SHALL be dropped, with no state change.

Reset
REQ-026 On rst the module SHALL set state IDLE, counters 0, FIFO empty, tx_serial 1, busy 0, done 0, tx_ready 1, fifo_count 0; a frame in progress SHALL be abandoned with the line high on the next cycle.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state encodings and the parity and stop-bit mode constants, for reuse by a future RX.
REQ-028 The FIFO SHALL be a sub-module uart_tx_fifo (synchronous, registered count); the FSM, shift register and tick counter SHALL stay in uart_tx_param.

Verification
REQ-029 Defaults, no parity, 1 stop, write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each held 8 ticks; one done pulse.
REQ-030 parity_en=1, even, write 0x07 -> parity bit 1; repeat with parity_odd=1 -> parity bit 0.
REQ-031 stop2=1, write 0x00 -> stop level held high 16 ticks before done.
REQ-032 Six writes back-to-back while idle -> first pops immediately, five accepted, sixth dropped with tx_ready=0; four frames follow with no idle cycle between them.
REQ-033 DATA_BITS=5, OS_RATE=16, write 0x1F -> start bit then 5 ones, each 16 ticks, then stop.
REQ-034 rst asserted during DATA bit 3 -> tx_serial=1, busy=0, fifo_count=0 next cycle; no done pulse.
